// File: rtl/seq_fp_div_if.sv
// Operand/result handshake bundle for seq_fp_div: valid/ready in, valid/ready out.
interface seq_fp_div_if #(
  parameter int sig_width = 23,
  parameter int exp_width = 8
);
  localparam int isize = sig_width + exp_width + 1;

  logic             in_valid;
  logic             in_ready;
  logic [isize-1:0] a;
  logic [isize-1:0] b;
  logic [2:0]       rnd;
  logic             out_valid;
  logic             out_ready;
  logic [isize-1:0] z;
  logic [7:0]       status;

  modport master (
    output in_valid, a, b, rnd, out_ready,
    input  in_ready, out_valid, z, status
  );

  modport slave (
    input  in_valid, a, b, rnd, out_ready,
    output in_ready, out_valid, z, status
  );
endinterface

// File: rtl/seq_fp_div.sv
// Multi-cycle IEEE-754 divider z = a / b: radix-2 restoring mantissa divide,
// early exit for special operands, subnormals flushed to zero.
module seq_fp_div #(
  parameter int sig_width = 23,
  parameter int exp_width = 8
) (
  input  logic        clk,
  input  logic        rst,
  seq_fp_div_if.slave bus
);
  localparam int isize  = sig_width + exp_width + 1;
  localparam int n_iter = sig_width + 3;
  localparam int CW     = $clog2(n_iter);
  localparam int EW2    = exp_width + 2;
  localparam int RW     = sig_width + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0] ST_DZ   = 8'h80;
  localparam logic [7:0] ST_INX  = 8'h20;
  localparam logic [7:0] ST_HUGE = 8'h10;
  localparam logic [7:0] ST_TINY = 8'h08;
  localparam logic [7:0] ST_INV  = 8'h04;
  localparam logic [7:0] ST_INF  = 8'h02;
  localparam logic [7:0] ST_ZERO = 8'h01;

  localparam logic signed [EW2-1:0] BIAS    = EW2'((1 << (exp_width - 1)) - 1);
  localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << exp_width) - 1);

  logic [2:0]              state_q, state_d;
  logic [isize-1:0]        a_q, a_d, b_q, b_d;
  logic [2:0]              rnd_q, rnd_d;
  logic                    sign_q, sign_d;
  logic signed [EW2-1:0]   exp_q, exp_d;
  logic [RW-1:0]           rem_q, rem_d;
  logic [sig_width:0]      div_q, div_d;
  logic [n_iter-1:0]       quo_q, quo_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [isize-1:0]        z_q, z_d;
  logic [7:0]              status_q, status_d;

  logic                    sa, sb, sgn;
  logic [exp_width-1:0]    ea, eb;
  logic [sig_width-1:0]    fa, fb;
  logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sa  = a_q[isize-1];
  assign sb  = b_q[isize-1];
  assign sgn = sa ^ sb;
  assign ea  = a_q[isize-2 -: exp_width];
  assign eb  = b_q[isize-2 -: exp_width];
  assign fa  = a_q[sig_width-1:0];
  assign fb  = b_q[sig_width-1:0];

  // A zero exponent field covers both true zero and flushed subnormals.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  logic                    step_ge;
  logic [RW-1:0]           rem_sub, rem_nxt;

  assign step_ge = (rem_q >= {1'b0, div_q});
  assign rem_sub = rem_q - {1'b0, div_q};
  assign rem_nxt = step_ge ? rem_sub : rem_q;

  logic [n_iter-1:0]       q_norm;
  logic signed [EW2-1:0]   exp_n, exp_r;
  logic [sig_width:0]      mant;
  logic                    g_bit, r_bit, s_bit, inexact, rup;
  logic [sig_width+1:0]    mant_r;
  logic                    huge, tiny;

  assign q_norm  = quo_q[n_iter-1] ? quo_q : {quo_q[n_iter-2:0], 1'b0};
  assign exp_n   = quo_q[n_iter-1] ? exp_q : exp_q - EW2'(1);
  assign mant    = q_norm[n_iter-1:2];
  assign g_bit   = q_norm[1];
  assign r_bit   = q_norm[0];
  assign s_bit   = (rem_q != '0);
  assign inexact = g_bit | r_bit | s_bit;

  always_comb begin
    case (rnd_q)
      3'd0:    rup = g_bit & (r_bit | s_bit | mant[0]);
      3'd1:    rup = 1'b0;
      3'd2:    rup = ~sign_q & inexact;
      3'd3:    rup = sign_q & inexact;
      3'd4:    rup = g_bit;
      default: rup = inexact;
    endcase
  end

  assign mant_r = {1'b0, mant} + {{(sig_width+1){1'b0}}, rup};
  assign exp_r  = exp_n + EW2'(mant_r[sig_width+1]);
  assign huge   = (exp_r >= EXP_MAX);
  assign tiny   = exp_r[EW2-1] || (exp_r == '0);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rnd_d    = rnd_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          rnd_d   = bus.rnd;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        sign_d  = sgn;
        state_d = S_DONE;
        // inf/0 lands in the inf/x branch, so divide_by_zero needs a finite dividend.
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          z_d      = {1'b0, {exp_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};
          status_d = ST_INV;
        end else if (a_inf) begin
          z_d      = {sgn, {exp_width{1'b1}}, {sig_width{1'b0}}};
          status_d = ST_INF;
        end else if (b_zero) begin
          z_d      = {sgn, {exp_width{1'b1}}, {sig_width{1'b0}}};
          status_d = ST_INF | ST_DZ;
        end else if (a_zero || b_inf) begin
          z_d      = {sgn, {(isize-1){1'b0}}};
          status_d = ST_ZERO;
        end else begin
          rem_d   = {1'b0, 1'b1, fa};
          div_d   = {1'b1, fb};
          exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        quo_d = {quo_q[n_iter-2:0], step_ge};
        rem_d = {rem_nxt[RW-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(n_iter - 1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        state_d = S_DONE;
        if (huge) begin
          if ((rnd_q == 3'd1) || ((rnd_q == 3'd2) && sign_q) || ((rnd_q == 3'd3) && !sign_q)) begin
            z_d      = {sign_q, {(exp_width-1){1'b1}}, 1'b0, {sig_width{1'b1}}};
            status_d = ST_HUGE | ST_INX;
          end else begin
            z_d      = {sign_q, {exp_width{1'b1}}, {sig_width{1'b0}}};
            status_d = ST_HUGE | ST_INX | ST_INF;
          end
        end else if (tiny) begin
          if (((rnd_q == 3'd2) && !sign_q) || ((rnd_q == 3'd3) && sign_q) || (rnd_q >= 3'd5)) begin
            z_d      = {sign_q, {(exp_width-1){1'b0}}, 1'b1, {sig_width{1'b0}}};
            status_d = ST_TINY | ST_INX;
          end else begin
            z_d      = {sign_q, {(isize-1){1'b0}}};
            status_d = ST_TINY | ST_INX | ST_ZERO;
          end
        end else begin
          z_d      = {sign_q, exp_r[exp_width-1:0], mant_r[sig_width-1:0]};
          status_d = inexact ? ST_INX : 8'h00;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rnd_q    <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      z_q      <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rnd_q    <= rnd_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      z_q      <= z_d;
      status_q <= status_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.z         = z_q;
  assign bus.status    = status_q;
endmodule
